// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache memory responder
// and the cache controller side of the refill/write-back link.
package cache_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WBEAT,
        RBEAT,
        ACK
    } mem_state_t;

    localparam int DEFAULT_BLOCK_SIZE = 32;
    localparam int BLOCK_OFFSET_W = $clog2(DEFAULT_BLOCK_SIZE);

    function automatic int beats_per_block(
        input int block_size,
        input int data_width
    );
        return block_size * 8 / data_width;
    endfunction

endpackage

// File: rtl/mem_word_store.sv
// Backing store: single address port, synchronous write,
// combinational read of the addressed word.
module mem_word_store #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS = 1024,
    localparam int IDX_W = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/cache_memory_responder.sv
// Memory-side responder: accepts one block request, waits the access
// latency, then absorbs a write-back burst or streams a refill burst.
module cache_memory_responder
    import cache_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int BLOCK_SIZE = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic                     wr_valid,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     wr_ready,
    output logic                     rd_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_last,
    input  logic                     rd_ready,
    output logic                     wb_ack,
    output logic                     busy
);

    localparam int BEATS = beats_per_block(BLOCK_SIZE, DATA_WIDTH);
    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int BEAT_W = $clog2(BEATS) + 1;
    localparam int LAT_W = $clog2(LATENCY + 2);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY);

    mem_state_t state, state_next;
    logic [BEAT_W-1:0] beat, beat_next;
    logic [LAT_W-1:0] lat, lat_next;
    logic [ADDRESS_WIDTH-1:0] block, block_next;
    logic is_write, is_write_next;
    logic rd_load;
    logic store_wr;
    logic [ADDRESS_WIDTH-1:0] idx_block;
    logic [BEAT_W-1:0] idx_beat;
    logic [IDX_W-1:0] store_addr;
    logic [DATA_WIDTH-1:0] store_rdata;

    // Store size is a multiple of the block, so truncation is the wrap.
    function automatic logic [IDX_W-1:0] word_index(
        input logic [ADDRESS_WIDTH-1:0] blk,
        input logic [BEAT_W-1:0] bt
    );
        logic [ADDRESS_WIDTH-1:0] word;
        word = blk * ADDRESS_WIDTH'(BEATS) + ADDRESS_WIDTH'(bt);
        return word[IDX_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        beat_next = beat;
        lat_next = lat;
        block_next = block;
        is_write_next = is_write;
        rd_load = 1'b0;
        store_wr = 1'b0;
        idx_block = block;
        idx_beat = beat;
        unique case (state)
            IDLE: begin
                idx_block = req_addr >> OFF_W;
                idx_beat = '0;
                if (req_valid) begin
                    block_next = req_addr >> OFF_W;
                    is_write_next = req_write;
                    beat_next = '0;
                    lat_next = LAT_LOAD;
                    if (LATENCY == 0) begin
                        state_next = req_write ? WBEAT : RBEAT;
                        rd_load = !req_write;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                idx_beat = '0;
                if (lat <= LAT_W'(1)) begin
                    state_next = is_write ? WBEAT : RBEAT;
                    rd_load = !is_write;
                end else begin
                    lat_next = lat - LAT_W'(1);
                end
            end
            WBEAT: begin
                if (wr_valid) begin
                    store_wr = 1'b1;
                    if (beat == LAST_BEAT) begin
                        beat_next = '0;
                        state_next = ACK;
                    end else begin
                        beat_next = beat + BEAT_W'(1);
                    end
                end
            end
            RBEAT: begin
                // Prefetch the next word so rd_data can be a register.
                idx_beat = beat + BEAT_W'(1);
                if (rd_ready) begin
                    if (beat == LAST_BEAT) begin
                        beat_next = '0;
                        state_next = IDLE;
                    end else begin
                        beat_next = beat + BEAT_W'(1);
                        rd_load = 1'b1;
                    end
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat <= '0;
            lat <= '0;
            block <= '0;
            is_write <= 1'b0;
            rd_data <= '0;
        end else begin
            beat <= beat_next;
            lat <= lat_next;
            block <= block_next;
            is_write <= is_write_next;
            if (rd_load) begin
                rd_data <= store_rdata;
            end
        end
    end

    assign store_addr = word_index(idx_block, idx_beat);

    mem_word_store #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_WORDS(MEM_WORDS)
    ) u_store (
        .clk(clk),
        .wr_en(store_wr),
        .addr(store_addr),
        .wr_data(wr_data),
        .rd_data(store_rdata)
    );

    assign req_ready = (state == IDLE);
    assign wr_ready = (state == WBEAT);
    assign rd_valid = (state == RBEAT);
    assign rd_last = (state == RBEAT) && (beat == LAST_BEAT);
    assign wb_ack = (state == ACK);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cache_memory_responder.sv
// Self-checking bench: vector table, corner sequences and random
// traffic against a word-array reference of the backing store.
module tb_cache_memory_responder;

    localparam int BEATS = 8;
    localparam int MEMW = 1024;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_ready;
    logic req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic wr_valid = 1'b0;
    logic [31:0] wr_data = '0;
    logic wr_ready;
    logic rd_valid;
    logic [31:0] rd_data;
    logic rd_last;
    logic rd_ready = 1'b0;
    logic wb_ack;
    logic busy;

    logic z_req_valid = 1'b0;
    logic z_req_ready;
    logic z_req_write = 1'b0;
    logic [31:0] z_req_addr = 32'h60;
    logic z_wr_valid = 1'b0;
    logic [31:0] z_wr_data = '0;
    logic z_wr_ready;
    logic z_rd_valid;
    logic [31:0] z_rd_data;
    logic z_rd_last;
    logic z_rd_ready = 1'b0;
    logic z_wb_ack;
    logic z_busy;

    always #5 clk = ~clk;

    cache_memory_responder #(.LATENCY(LAT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .rd_ready(rd_ready), .wb_ack(wb_ack), .busy(busy)
    );

    cache_memory_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_addr(z_req_addr),
        .wr_valid(z_wr_valid), .wr_data(z_wr_data), .wr_ready(z_wr_ready),
        .rd_valid(z_rd_valid), .rd_data(z_rd_data), .rd_last(z_rd_last),
        .rd_ready(z_rd_ready), .wb_ack(z_wb_ack), .busy(z_busy)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] base;
        int          mode;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cyc = -1;
    int acc_cyc = -1;
    int ack_count = 0;

    logic [31:0] ref_mem [MEMW];
    logic [31:0] wbuf [BEATS];
    logic [31:0] rbuf [BEATS];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wb_ack) begin
            ack_cyc = cyc;
            ack_count++;
        end
        if (req_valid && req_ready && acc_cyc < 0) acc_cyc = cyc;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic int widx(input logic [31:0] a, input int k);
        logic [31:0] w;
        w = (a >> 5) * 32'd8 + 32'(k);
        return int'(w % 32'd1024);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic w, input logic [31:0] a);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr = a;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        chk("req_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input int gap_mode,
                            input int abort_at, input bit hold,
                            input logic [31:0] hold_addr);
        int k = 0;
        int n = 0;
        int first_rdy = -1;
        int acks0;
        send_req(1'b1, a);
        if (hold) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr = hold_addr;
            acc_cyc = -1;
        end
        acks0 = ack_count;
        while (k < BEATS && n < 200) begin
            if (abort_at >= 0 && k == abort_at) break;
            wr_valid = (gap_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            wr_data = wbuf[k];
            if (wr_ready && first_rdy < 0) first_rdy = n;
            if (wr_valid && wr_ready) begin
                ref_mem[widx(a, k)] = wbuf[k];
                k++;
            end
            tick();
            n++;
        end
        wr_valid = 1'b0;
        chk("wr_latency", first_rdy, LAT);
        if (abort_at >= 0) begin
            reset_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_wb_ack", wb_ack, 0);
            chk("rst_rd_data", rd_data, 0);
            tick();
            reset_n = 1'b1;
            tick();
            chk("abort_no_ack", ack_count, acks0);
            return;
        end
        chk("wr_beats", k, BEATS);
        if (gap_mode == 0) chk("wr_cycles", n, LAT + BEATS);
        chk("wb_ack_pulse", wb_ack, 1);
        chk("ack_req_ready", req_ready, 0);
        tick();
        chk("wb_ack_drop", wb_ack, 0);
        chk("req_ready_after_ack", req_ready, 1);
        chk("ack_count", ack_count - acks0, 1);
    endtask

    task automatic do_read(input logic [31:0] a, input int stall_mode,
                           input bit pre_sent);
        int k = 0;
        int n = 0;
        int lat = 0;
        int stall = 0;
        int seen = -1;
        logic [31:0] hold_d;
        logic hold_l;
        if (pre_sent) begin
            tick();
            req_valid = 1'b0;
        end else begin
            send_req(1'b0, a);
        end
        while (!rd_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("rd_latency", lat, LAT);
        while (k < BEATS && n < 200) begin
            if (k != seen) begin
                seen = k;
                if (stall_mode == 1) stall = (k == 2 || k == 5) ? 3 : 0;
                else if (stall_mode == 2) stall = $urandom_range(0, 2);
                else stall = 0;
                hold_d = rd_data;
                hold_l = rd_last;
            end else begin
                chk("rd_valid_hold", rd_valid, 1);
                chk("rd_data_stable", rd_data, hold_d);
                chk("rd_last_stable", rd_last, hold_l);
            end
            rd_ready = (stall == 0);
            if (stall > 0) stall--;
            if (rd_valid && rd_ready) begin
                rbuf[k] = rd_data;
                chk("rd_data", rd_data, ref_mem[widx(a, k)]);
                chk("rd_last", rd_last, k == BEATS - 1);
                k++;
            end
            tick();
            n++;
        end
        rd_ready = 1'b0;
        chk("rd_beats", k, BEATS);
        if (stall_mode == 0) chk("rd_cycles", n, BEATS);
        chk("rd_done_valid", rd_valid, 0);
        chk("rd_done_req_ready", req_ready, 1);
    endtask

    initial begin
        vec_t vt[7];
        logic [31:0] a;
        logic [31:0] wq[$];

        vt[0] = '{1'b1, 32'h0000_0040, 32'h0000_00A0, 0};
        vt[1] = '{1'b0, 32'h0000_0040, 32'h0000_00A0, 0};
        vt[2] = '{1'b1, 32'h0000_1000, 32'h1000_0000, 1};
        vt[3] = '{1'b0, 32'h0000_0000, 32'h1000_0000, 1};
        vt[4] = '{1'b0, 32'h0000_005F, 32'h0000_00A0, 2};
        vt[5] = '{1'b1, 32'hFFFF_FFE0, 32'h0000_00E0, 0};
        vt[6] = '{1'b0, 32'h0000_0FE0, 32'h0000_00E0, 2};

        tick();
        tick();
        chk("reset_req_ready", req_ready, 1);
        chk("reset_wr_ready", wr_ready, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_rd_last", rd_last, 0);
        chk("reset_wb_ack", wb_ack, 0);
        chk("reset_busy", busy, 0);
        reset_n = 1'b1;
        tick();

        // Zero-latency instance: data phase right after acceptance.
        z_req_valid = 1'b1;
        z_req_write = 1'b1;
        chk("z_req_ready", z_req_ready, 1);
        tick();
        z_req_valid = 1'b0;
        chk("z_wr_ready_lat0", z_wr_ready, 1);
        for (int k = 0; k < BEATS; k++) begin
            z_wr_valid = 1'b1;
            z_wr_data = 32'h0000_00D0 + 32'(k);
            tick();
        end
        z_wr_valid = 1'b0;
        chk("z_wb_ack", z_wb_ack, 1);
        tick();
        z_req_valid = 1'b1;
        z_req_write = 1'b0;
        tick();
        z_req_valid = 1'b0;
        chk("z_rd_valid_lat0", z_rd_valid, 1);
        z_rd_ready = 1'b1;
        for (int k = 0; k < BEATS; k++) begin
            chk("z_rd_data", z_rd_data, 32'h0000_00D0 + 32'(k));
            chk("z_rd_last", z_rd_last, k == BEATS - 1);
            tick();
        end
        z_rd_ready = 1'b0;
        chk("z_rd_end", z_rd_valid, 0);

        for (int i = 0; i < 7; i++) begin
            if (vt[i].wr) begin
                for (int k = 0; k < BEATS; k++) wbuf[k] = vt[i].base + 32'(k);
                do_write(vt[i].addr, vt[i].mode, -1, 1'b0, '0);
            end else begin
                do_read(vt[i].addr, vt[i].mode, 1'b0);
                for (int k = 0; k < BEATS; k++)
                    chk("vec_rd", rbuf[k], vt[i].base + 32'(k));
            end
        end

        // Reset after three write beats: partial update, no ack.
        for (int k = 0; k < BEATS; k++) wbuf[k] = 32'hB0 + 32'(k);
        do_write(32'h80, 0, -1, 1'b0, '0);
        for (int k = 0; k < BEATS; k++) wbuf[k] = 32'hC0 + 32'(k);
        do_write(32'h80, 0, 3, 1'b0, '0);
        do_read(32'h80, 1, 1'b0);
        for (int k = 0; k < BEATS; k++)
            chk("abort_rd", rbuf[k], (k < 3) ? 32'hC0 + 32'(k) : 32'hB0 + 32'(k));

        // Request held through a write-back.
        for (int k = 0; k < BEATS; k++) wbuf[k] = 32'h5500 + 32'(k);
        do_write(32'h100, 0, -1, 1'b1, 32'h100);
        do_read(32'h100, 0, 1'b1);
        chk("busy_accept_gap", acc_cyc - ack_cyc, 1);

        repeat (30) begin
            if (wq.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = $urandom;
                for (int k = 0; k < BEATS; k++) wbuf[k] = $urandom;
                do_write(a, $urandom_range(0, 1), -1, 1'b0, '0);
                wq.push_back(a);
            end else begin
                a = wq[$urandom_range(0, wq.size() - 1)];
                a = a ^ ($urandom & 32'hFFFF_F01F);
                do_read(a, $urandom_range(0, 2), 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
